// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared sizing helpers for the synchronous FIFO: depth and pointer/count width
// derived from the address width.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 16;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers and count carry one extra bit so full and empty stay distinguishable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage array: one registered write port, one combinational read port,
// contents cleared by either reset.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (srst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[addr_in] <= data_in;
    end
  end

  assign data_out = mem_q[addr_out];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// First-word-fall-through synchronous FIFO: pointer, occupancy and threshold
// flag control around sync_fifo_ram, valid/ready on both sides.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int PW = cnt_width(ADDR_WIDTH);
  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t AFULL_C  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_THRESH);

  ptr_t wr_ptr_q, rd_ptr_q, count_q, count_nxt;
  logic full, empty, push, pop;
  logic afull_q, aempty_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  // Handshake readies depend only on registers; no push-through when full.
  assign s_ready = !full;
  assign m_valid = !empty;
  assign push    = s_valid && !full;
  assign pop     = m_ready && !empty;

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + ptr_t'(1);
      2'b01:   count_nxt = count_q - ptr_t'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Flags come from the next count so they line up with count every cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      count_q  <= count_nxt;
      afull_q  <= (count_nxt >= AFULL_C);
      aempty_q <= (count_nxt <= AEMPTY_C);
    end
  end

  assign count        = count_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

  sync_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .wr_en    (push),
    .addr_in  (wr_ptr_q[ADDR_WIDTH-1:0]),
    .data_in  (s_data),
    .addr_out (rd_ptr_q[ADDR_WIDTH-1:0]),
    .data_out (m_data)
  );

  a_sdata_hold: assert property (@(posedge aclk) disable iff (!aresetn || srst)
    (s_valid && !s_ready) |=> (!s_valid || $stable(s_data)));

  a_count_ptrs: assert property (@(posedge aclk) disable iff (!aresetn)
    count_q == ptr_t'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed vector bench for sync_fifo_ctrl (DEPTH=16): table of handshake
// vectors plus hand-written latency and reset sequences.
module tb_sync_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          srst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;

  int n_vec = 0;
  int n_mis = 0;

  always #5 aclk = ~aclk;

  sync_fifo_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (1)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .srst         (srst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          exp_sr;
    logic          exp_mv;
    logic          chk_d;
    logic [DW-1:0] exp_md;
    logic [AW:0]   exp_cnt;
    logic          exp_af;
    logic          exp_ae;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic sv, input logic [DW-1:0] sd, input logic mr,
                              input logic esr, input logic emv, input logic cd,
                              input logic [DW-1:0] emd, input int ecnt,
                              input logic eaf, input logic eae);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr;
    v.exp_sr = esr; v.exp_mv = emv; v.chk_d = cd; v.exp_md = emd;
    v.exp_cnt = (AW+1)'(ecnt); v.exp_af = eaf; v.exp_ae = eae;
    return v;
  endfunction

  // Head word of the streaming phase: 5 preloaded words then the streamed ones.
  function automatic logic [DW-1:0] hd(input int x);
    return (x < 5) ? DW'(16'h0100 + x) : DW'(16'h0200 + x - 5);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic sr);
    s_valid = sv; s_data = sd; m_ready = mr; srst = sr;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_s_ready"}, 0, 32'(s_ready), 32'd1);
    chk({nm, "_m_valid"}, 0, 32'(m_valid), 32'd0);
    chk({nm, "_count"}, 0, 32'(count), 32'd0);
    chk({nm, "_afull"}, 0, 32'(almost_full), 32'd0);
    chk({nm, "_aempty"}, 0, 32'(almost_empty), 32'd1);
    chk({nm, "_m_data"}, 0, 32'(m_data), 32'd0);
  endtask

  initial begin
    // Idle after reset
    vq.push_back(mk(0, 16'h0, 0, 1, 0, 1, 16'h0000, 0, 0, 1));
    // Fill 16 words with no pops
    for (int i = 1; i <= 16; i++)
      vq.push_back(mk(1, DW'(i), 0, (i != 16), 1, 1, 16'h0001, i, (i >= 14), (i <= 1)));
    // 17th offer must be refused
    vq.push_back(mk(1, 16'h0011, 0, 0, 1, 1, 16'h0001, 16, 1, 0));
    // Drain all 16 in order
    for (int k = 1; k <= 16; k++)
      vq.push_back(mk(0, 16'h0, 1, 1, (k < 16), (k < 16), DW'(k + 1), 16 - k, (k <= 2), (k >= 15)));
    // Preload 5, then 40 cycles of simultaneous push and pop
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1, DW'(16'h0100 + i), 0, 1, 1, 1, 16'h0100, i + 1, 0, (i == 0)));
    for (int j = 0; j < 40; j++)
      vq.push_back(mk(1, DW'(16'h0200 + j), 1, 1, 1, 1, hd(j + 1), 5, 0, 0));
    for (int k = 1; k <= 5; k++)
      vq.push_back(mk(0, 16'h0, 1, 1, (k < 5), (k < 5), hd(40 + k), 5 - k, 0, (k >= 4)));

    #22 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    foreach (vq[i]) begin
      step(vq[i].sv, vq[i].sd, vq[i].mr, 1'b0);
      chk("s_ready", i, 32'(s_ready), 32'(vq[i].exp_sr));
      chk("m_valid", i, 32'(m_valid), 32'(vq[i].exp_mv));
      chk("count", i, 32'(count), 32'(vq[i].exp_cnt));
      chk("almost_full", i, 32'(almost_full), 32'(vq[i].exp_af));
      chk("almost_empty", i, 32'(almost_empty), 32'(vq[i].exp_ae));
      if (vq[i].chk_d) chk("m_data", i, 32'(m_data), 32'(vq[i].exp_md));
    end

    // Single word into an empty FIFO: visible only after the push edge
    s_valid = 1'b1; s_data = 16'hBEEF; m_ready = 1'b0;
    #1;
    chk("beef_same_cycle_m_valid", 0, 32'(m_valid), 32'd0);
    @(posedge aclk);
    #1;
    chk("beef_m_valid", 0, 32'(m_valid), 32'd1);
    chk("beef_m_data", 0, 32'(m_data), 32'hBEEF);
    chk("beef_count", 0, 32'(count), 32'd1);
    step(0, 16'h0, 1, 0);
    chk("beef_pop_count", 0, 32'(count), 32'd0);
    chk("beef_pop_m_valid", 0, 32'(m_valid), 32'd0);

    // Synchronous reset with 8 entries and a live handshake
    for (int i = 0; i < 8; i++) step(1, DW'(16'h00A0 + i), 0, 0);
    chk("srst_pre_count", 0, 32'(count), 32'd8);
    step(1, 16'h00CC, 1, 1);
    step(0, 16'h0, 0, 0);
    chk_idle("srst");

    // Asynchronous reset mid-cycle with 8 entries
    for (int i = 0; i < 8; i++) step(1, DW'(16'h00D0 + i), 0, 0);
    chk("arst_pre_count", 0, 32'(count), 32'd8);
    chk("arst_pre_m_data", 0, 32'(m_data), 32'h00D0);
    s_valid = 1'b0; m_ready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk_idle("arst_async");
    #3 aresetn = 1'b1;
    step(0, 16'h0, 0, 0);
    chk_idle("arst_after");

    // FIFO usable again after reset
    step(1, 16'h1234, 0, 0);
    chk("post_m_valid", 0, 32'(m_valid), 32'd1);
    chk("post_m_data", 0, 32'(m_data), 32'h1234);
    chk("post_count", 0, 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
